// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
//   Shared definitions for the serial magnitude comparator:
//     - controller state encoding (2-bit constants)
//     - one-hot result encoding, ordered {gt, eq, lt}
//     - counter-width helper
//   No ports (package).
// -----------------------------------------------------------------------------
package cmp_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_CMP  = 2'b01;
  localparam state_t ST_DONE = 2'b10;

  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_LT = 3'b001;

  // Bit-position counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/bit_cmp_cell.sv
// -----------------------------------------------------------------------------
// bit_cmp_cell
//   Combinational 1-bit magnitude compare cell.
//   Ports:
//     a_i  in  1  bit of operand A
//     b_i  in  1  bit of operand B
//     y1_o out 1  A > B
//     y2_o out 1  A == B
//     y3_o out 1  A < B
// -----------------------------------------------------------------------------
module bit_cmp_cell (
  input  logic a_i,
  input  logic b_i,
  output logic y1_o,
  output logic y2_o,
  output logic y3_o
);

  assign y1_o = a_i & ~b_i;
  assign y2_o = ~(a_i ^ b_i);
  assign y3_o = ~a_i & b_i;

endmodule

// File: rtl/serial_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// serial_magnitude_comparator
//   Unsigned WIDTH-bit magnitude comparator that walks the operands MSB-first,
//   one bit pair per clock, through a single bit_cmp_cell.
//   Ports:
//     clk        in   1      rising-edge clock
//     rst_n      in   1      asynchronous reset, active-low
//     in_valid   in   1      operand pair valid
//     in_ready   out  1      operands can be accepted (IDLE only)
//     a_in       in   WIDTH  operand A
//     b_in       in   WIDTH  operand B
//     out_valid  out  1      result valid (DONE only)
//     out_ready  in   1      downstream accepts result
//     gt/eq/lt   out  1      one-hot registered result
//     busy       out  1      comparison in progress (CMP)
// -----------------------------------------------------------------------------
module serial_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q,   state_d;
  logic [WIDTH-1:0] sh_a_q,    sh_a_d;
  logic [WIDTH-1:0] sh_b_q,    sh_b_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic             decided_q, decided_d;
  logic [2:0]       res_q,     res_d;

  logic cell_gt, cell_eq, cell_lt;
  logic first_diff;

  // The cell always looks at the current MSBs; the shift registers bring
  // each lower bit pair up to that position in turn.
  bit_cmp_cell u_cell (
    .a_i  (sh_a_q[WIDTH-1]),
    .b_i  (sh_b_q[WIDTH-1]),
    .y1_o (cell_gt),
    .y2_o (cell_eq),
    .y3_o (cell_lt)
  );

  // Only the first differing pair may set the result; afterwards it is sticky.
  assign first_diff = ~decided_q & ~cell_eq;

  always_comb begin
    state_d   = state_q;
    sh_a_d    = sh_a_q;
    sh_b_d    = sh_b_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    res_d     = res_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sh_a_d    = a_in;
          sh_b_d    = b_in;
          cnt_d     = CW'(WIDTH - 1);
          decided_d = 1'b0;
          res_d     = '0;
          state_d   = ST_CMP;
        end
      end

      ST_CMP: begin
        if (first_diff) begin
          // On a differing pair exactly one of y1/y3 is set, so this is one-hot.
          res_d     = {cell_gt, 1'b0, cell_lt};
          decided_d = 1'b1;
        end
        if ((first_diff && EARLY_EXIT) || (cnt_q == '0)) begin
          // Reaching the LSB without any difference means the operands match.
          if (!decided_q && cell_eq) begin
            res_d = RES_EQ;
          end
          state_d = ST_DONE;
        end else begin
          sh_a_d = sh_a_q << 1;
          sh_b_d = sh_b_q << 1;
          cnt_d  = cnt_q - CW'(1);
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sh_a_q    <= '0;
      sh_b_q    <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      sh_a_q    <= sh_a_d;
      sh_b_q    <= sh_b_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      res_q     <= res_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_CMP);
  assign gt        = res_q[2];
  assign eq        = res_q[1];
  assign lt        = res_q[0];

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// tb_serial_magnitude_comparator
//   Three comparator instances share one clock and reset:
//     0: WIDTH=8, EARLY_EXIT=1 (out_ready stalled in periodic windows)
//     1: WIDTH=8, EARLY_EXIT=0 (random out_ready)
//     2: WIDTH=1, EARLY_EXIT=1 (out_ready tied high, back-to-back)
//   Drivers push the expected result and due edge into per-instance queues;
//   a monitor pops and compares whenever a result is presented.
// -----------------------------------------------------------------------------
module tb_serial_magnitude_comparator;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0] in_valid, in_ready, out_valid, out_ready, gt, eq, lt, busy;
  logic [7:0]   a_in [N];
  logic [7:0]   b_in [N];

  serial_magnitude_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_ee (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a_in(a_in[0]), .b_in(b_in[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .gt(gt[0]), .eq(eq[0]), .lt(lt[0]), .busy(busy[0]));

  serial_magnitude_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_full (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a_in(a_in[1]), .b_in(b_in[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .gt(gt[1]), .eq(eq[1]), .lt(lt[1]), .busy(busy[1]));

  serial_magnitude_comparator #(.WIDTH(1), .EARLY_EXIT(1'b1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a_in(a_in[2][0:0]), .b_in(b_in[2][0:0]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .gt(gt[2]), .eq(eq[2]), .lt(lt[2]), .busy(busy[2]));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] res;   // {gt, eq, lt}
    int         due;   // edge at which out_valid is first sampled high
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %0h, want %0h (edge %0d)", name, idx, act, want, cyc);
    end
  endtask

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qfront(input int i);
    case (i)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpush(input int i, input exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qpop(input int i);
    exp_t e;
    case (i)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  function automatic int w_of(input int i);
    return (i == 2) ? 1 : 8;
  endfunction

  function automatic bit ee_of(input int i);
    return (i != 1);
  endfunction

  // Reference: plain unsigned comparison; the deciding bit is the highest set
  // bit of a^b, so with early exit the result is due that many bits in.
  function automatic exp_t expect_of(input int i, input logic [7:0] a, input logic [7:0] b, input int acc);
    exp_t e;
    int   w;
    int   x;
    w = w_of(i);
    x = int'(a ^ b);
    e.res = (a > b) ? 3'b100 : ((a == b) ? 3'b010 : 3'b001);
    if (!ee_of(i) || x == 0) e.due = acc + w + 1;
    else                     e.due = acc + w - $clog2(x + 1) + 2;
    return e;
  endfunction

  // Holds in_valid high with junk operands while the DUT cannot accept, then
  // presents the real pair once in_ready is seen.
  task automatic run_op(input int i, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] am;
    logic [7:0] bm;
    int waited;
    am = (i == 2) ? (a & 8'h01) : a;
    bm = (i == 2) ? (b & 8'h01) : b;
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready[i]) begin
        in_valid[i] = 1'b1;
        a_in[i] = am;
        b_in[i] = bm;
        qpush(i, expect_of(i, am, bm, cyc + 1));
        break;
      end
      in_valid[i] = 1'b1;
      a_in[i] = 8'($urandom);
      b_in[i] = 8'($urandom);
      waited++;
      if (waited > 200) begin
        check("accept_timeout", i, 32'(waited), 0);
        break;
      end
    end
    @(negedge clk);
    #1;
    check("busy_after_accept", i, busy[i], 1);
  endtask

  task automatic drive_inst(input int i, input int n_rand);
    logic [7:0] a;
    logic [7:0] b;
    for (int d = 0; d < 4; d++) begin
      if (i == 2) begin
        a = 8'(d >> 1);
        b = 8'(d & 1);
      end else begin
        case (d)
          0:       begin a = 8'hA5; b = 8'hA5; end
          1:       begin a = 8'h80; b = 8'h7F; end
          2:       begin a = 8'h00; b = 8'h01; end
          default: begin a = 8'hF0; b = 8'h0F; end
        endcase
      end
      run_op(i, a, b);
    end
    for (int r = 0; r < n_rand; r++) begin
      a = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (8'h01 << $urandom_range(0, 7));
        default: b = 8'($urandom);
      endcase
      run_op(i, a, b);
    end
    @(negedge clk);
    in_valid[i] = 1'b0;
  endtask

  always @(negedge clk) begin
    out_ready[0] = (cyc % 40 < 6) ? 1'b0 : ($urandom_range(0, 3) != 0);
    out_ready[1] = 1'($urandom_range(0, 1));
    out_ready[2] = 1'b1;
  end

  bit seen [N];

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (mon_en && rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (busy[i]) check("busy_excl", i, {30'd0, in_ready[i], out_valid[i]}, 0);
        if (out_valid[i]) begin
          check("onehot", i, $countones({gt[i], eq[i], lt[i]}), 1);
          check("in_ready_low", i, in_ready[i], 0);
          check("pending_expect", i, (qsize(i) > 0), 1);
          if (qsize(i) > 0) begin
            e = qfront(i);
            if (!seen[i]) begin
              check("latency_edge", i, cyc + 1, e.due);
              seen[i] = 1'b1;
            end
            check("result", i, {gt[i], eq[i], lt[i]}, e.res);
            if (out_ready[i]) begin
              qpop(i);
              seen[i] = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    int t;
    rst_n    = 1'b0;
    in_valid = '0;
    for (int i = 0; i < N; i++) begin
      a_in[i] = '0;
      b_in[i] = '0;
      seen[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      check("rst_in_ready", i, in_ready[i], 1);
      check("rst_out_valid", i, out_valid[i], 0);
      check("rst_busy", i, busy[i], 0);
      check("rst_result", i, {gt[i], eq[i], lt[i]}, 0);
    end
    rst_n = 1'b1;

    // Accept F0/0F, then reset in the second cycle after the accept edge.
    @(negedge clk);
    in_valid = '1;
    for (int i = 0; i < N; i++) begin
      a_in[i] = (i == 2) ? 8'h01 : 8'hF0;
      b_in[i] = (i == 2) ? 8'h00 : 8'h0F;
    end
    @(negedge clk);
    in_valid = '0;
    #1;
    check("abort_busy_before", 1, busy[1], 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check("abort_in_ready", i, in_ready[i], 1);
      check("abort_out_valid", i, out_valid[i], 0);
      check("abort_result", i, {gt[i], eq[i], lt[i]}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      check("abort_no_result", i, out_valid[i], 0);
      check("abort_idle", i, in_ready[i], 1);
    end
    mon_en = 1'b1;

    fork
      drive_inst(0, 60);
      drive_inst(1, 60);
      drive_inst(2, 60);
    join

    t = 0;
    while ((qsize(0) + qsize(1) + qsize(2)) > 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain", 0, qsize(0) + qsize(1) + qsize(2), 0);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
